uart_cmd_regfile: RTL



---
 rtl/uart_cmd_regfile.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_regfile.sv
// Decodes UART command packets into per-channel shadow/active configuration banks
// and streams readback frames (A5, ch, sel, value) to the UART transmitter.
module uart_cmd_regfile #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned PAT_WIDTH    = 32,
  parameter int unsigned ERR_CNT_W    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     func_reg,
  input  logic [87:0]                    rev_data,
  input  logic                           pack_done,
  input  logic [NUM_CHANNELS-1:0]        ch_busy,
  output logic [NUM_CHANNELS*8-1:0]      ctrl_o,
  output logic [NUM_CHANNELS*8-1:0]      duty_num_o,
  output logic [NUM_CHANNELS*16-1:0]     pulse_dessert_o,
  output logic [NUM_CHANNELS*8-1:0]      pulse_num_o,
  output logic [NUM_CHANNELS*PAT_WIDTH-1:0] pat_o,
  output logic [NUM_CHANNELS-1:0]        cfg_update,
  output logic [NUM_CHANNELS-1:0]        commit_pending,
  output logic                           cmd_ack,
  output logic                           cmd_err,
  output logic [ERR_CNT_W-1:0]           err_cnt,
  output logic [7:0]                     tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready
);

  localparam logic [7:0] FN_WR_HS  = 8'h01;
  localparam logic [7:0] FN_WR_LS  = 8'h02;
  localparam logic [7:0] FN_COMMIT = 8'h03;
  localparam logic [7:0] FN_READ   = 8'h04;
  localparam logic [7:0] TX_HEADER = 8'hA5;

  typedef enum logic [2:0] {TX_IDLE, TX_HDR, TX_CH, TX_SEL, TX_VAL} tx_state_t;

  tx_state_t state, state_nxt;

  logic [7:0]           sh_ctrl    [NUM_CHANNELS];
  logic [7:0]           sh_duty    [NUM_CHANNELS];
  logic [15:0]          sh_dessert [NUM_CHANNELS];
  logic [7:0]           sh_num     [NUM_CHANNELS];
  logic [PAT_WIDTH-1:0] sh_pat     [NUM_CHANNELS];
  logic [7:0]           act_ctrl    [NUM_CHANNELS];
  logic [7:0]           act_duty    [NUM_CHANNELS];
  logic [15:0]          act_dessert [NUM_CHANNELS];
  logic [7:0]           act_num     [NUM_CHANNELS];
  logic [PAT_WIDTH-1:0] act_pat     [NUM_CHANNELS];

  logic [7:0]  b1, b2, b3, b4, b5, b6, b7, b8, b9, b10, b11;
  logic [31:0] pat_field;
  logic        ch_ok, cmd_ok, accept, reject, read_accept;
  logic [7:0]  rd_byte;
  logic [31:0] rd_pat;
  logic [7:0]  rd_ch, rd_sel, rd_val;
  logic        unused_bits;

  assign b1  = rev_data[7:0];
  assign b2  = rev_data[15:8];
  assign b3  = rev_data[23:16];
  assign b4  = rev_data[31:24];
  assign b5  = rev_data[39:32];
  assign b6  = rev_data[47:40];
  assign b7  = rev_data[55:48];
  assign b8  = rev_data[63:56];
  assign b9  = rev_data[71:64];
  assign b10 = rev_data[79:72];
  assign b11 = rev_data[87:80];
  assign pat_field   = {b7, b8, b9, b10};
  assign unused_bits = ^{b11, pat_field};

  always_comb begin
    ch_ok  = ({24'd0, b1} < NUM_CHANNELS);
    cmd_ok = 1'b0;
    case (func_reg)
      FN_WR_HS, FN_WR_LS, FN_COMMIT: cmd_ok = ch_ok;
      FN_READ:  cmd_ok = ch_ok && (b2 <= 8'd8) && (state == TX_IDLE);
      default:  cmd_ok = 1'b0;
    endcase
    accept      = pack_done && cmd_ok;
    reject      = pack_done && !cmd_ok;
    read_accept = accept && (func_reg == FN_READ);
  end

  // Readback value is taken from the active bank at accept time, zero-extended pattern
  always_comb begin
    rd_byte = '0;
    rd_pat  = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (b1 == 8'(i)) begin
        rd_pat = 32'(act_pat[i]);
        case (b2)
          8'd0:    rd_byte = act_ctrl[i];
          8'd1:    rd_byte = act_duty[i];
          8'd2:    rd_byte = act_dessert[i][15:8];
          8'd3:    rd_byte = act_dessert[i][7:0];
          8'd4:    rd_byte = act_num[i];
          8'd5:    rd_byte = rd_pat[31:24];
          8'd6:    rd_byte = rd_pat[23:16];
          8'd7:    rd_byte = rd_pat[15:8];
          8'd8:    rd_byte = rd_pat[7:0];
          default: rd_byte = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ack        <= 1'b0;
      cmd_err        <= 1'b0;
      err_cnt        <= '0;
      cfg_update     <= '0;
      commit_pending <= '0;
      rd_ch          <= '0;
      rd_sel         <= '0;
      rd_val         <= '0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        sh_ctrl[i]     <= '0;
        sh_duty[i]     <= '0;
        sh_dessert[i]  <= '0;
        sh_num[i]      <= '0;
        sh_pat[i]      <= '0;
        act_ctrl[i]    <= '0;
        act_duty[i]    <= '0;
        act_dessert[i] <= '0;
        act_num[i]     <= '0;
        act_pat[i]     <= '0;
      end
    end else begin
      cmd_ack <= accept;
      cmd_err <= reject;
      if (reject && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
      if (read_accept) begin
        rd_ch  <= b1;
        rd_sel <= b2;
        rd_val <= rd_byte;
      end
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        cfg_update[i] <= 1'b0;
        // Apply reads shadow before this edge's write, so a same-cycle write lands in shadow only
        if (commit_pending[i] && !ch_busy[i]) begin
          act_ctrl[i]       <= sh_ctrl[i];
          act_duty[i]       <= sh_duty[i];
          act_dessert[i]    <= sh_dessert[i];
          act_num[i]        <= sh_num[i];
          act_pat[i]        <= sh_pat[i];
          commit_pending[i] <= 1'b0;
          cfg_update[i]     <= 1'b1;
        end
        if (accept && (b1 == 8'(i))) begin
          case (func_reg)
            FN_WR_HS: begin
              sh_duty[i]    <= b3;
              sh_dessert[i] <= {b4, b5};
              sh_num[i]     <= b6;
              sh_pat[i]     <= pat_field[PAT_WIDTH-1:0];
            end
            FN_WR_LS:  sh_ctrl[i]        <= b2;
            FN_COMMIT: commit_pending[i] <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= TX_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_data   = '0;
    case (state)
      TX_IDLE: if (read_accept) state_nxt = TX_HDR;
      TX_HDR: begin
        tx_valid = 1'b1;
        tx_data  = TX_HEADER;
        if (tx_ready) state_nxt = TX_CH;
      end
      TX_CH: begin
        tx_valid = 1'b1;
        tx_data  = rd_ch;
        if (tx_ready) state_nxt = TX_SEL;
      end
      TX_SEL: begin
        tx_valid = 1'b1;
        tx_data  = rd_sel;
        if (tx_ready) state_nxt = TX_VAL;
      end
      TX_VAL: begin
        tx_valid = 1'b1;
        tx_data  = rd_val;
        if (tx_ready) state_nxt = TX_IDLE;
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    ctrl_o          = '0;
    duty_num_o      = '0;
    pulse_dessert_o = '0;
    pulse_num_o     = '0;
    pat_o           = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      ctrl_o[i*8 +: 8]               = act_ctrl[i];
      duty_num_o[i*8 +: 8]           = act_duty[i];
      pulse_dessert_o[i*16 +: 16]    = act_dessert[i];
      pulse_num_o[i*8 +: 8]          = act_num[i];
      pat_o[i*PAT_WIDTH +: PAT_WIDTH] = act_pat[i];
    end
  end

endmodule
